// File: rtl/accum_cpu_pkg.sv
// Shared types for the parametrised accumulator CPU: FSM states, opcodes and
// ALU operation select.
package accum_cpu_pkg;

  typedef enum logic [3:0] {
    FETCH1 = 4'd0,
    FETCH2 = 4'd1,
    FETCH3 = 4'd2,
    ADD1   = 4'd3,
    ADD2   = 4'd4,
    SUB1   = 4'd5,
    SUB2   = 4'd6,
    AND1   = 4'd7,
    AND2   = 4'd8,
    INC1   = 4'd9,
    JMP1   = 4'd10,
    JC1    = 4'd11,
    JZ1    = 4'd12,
    MOV1   = 4'd13
  } state_e;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_INC = 3'd3;
  localparam logic [2:0] OP_JMP = 3'd4;
  localparam logic [2:0] OP_JC  = 3'd5;
  localparam logic [2:0] OP_JZ  = 3'd6;
  localparam logic [2:0] OP_MOV = 3'd7;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2
  } alu_sel_e;

endpackage

// File: rtl/accum_cpu_alu.sv
// Combinational ALU for the accumulator CPU: add with carry-out, subtract
// and bitwise AND.
module accum_cpu_alu
  import accum_cpu_pkg::*;
#(
  parameter int unsigned DW = 9
) (
  input  logic [DW-1:0] ac,
  input  logic [DW-1:0] dr,
  input  alu_sel_e      sel,
  output logic [DW-1:0] result,
  output logic          cout
);

  always_comb begin
    result = '0;
    cout   = 1'b0;
    case (sel)
      ALU_ADD: {cout, result} = {1'b0, ac} + {1'b0, dr};
      ALU_SUB: result = ac - dr;
      ALU_AND: result = ac & dr;
      default: ;
    endcase
  end

endmodule

// File: rtl/accum_cpu_param.sv
// Parametrised one-bus accumulator CPU with a ready-handshake memory port.
// Holds all architectural registers and the control FSM.
module accum_cpu_param
  import accum_cpu_pkg::*;
#(
  parameter int unsigned AW  = 6,
  parameter int unsigned DW  = 9,
  parameter int unsigned OPW = 3
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [DW-1:0] d,
  input  logic          mem_ready,
  output logic          read,
  output logic          write,
  output logic [AW-1:0] a,
  output logic [DW-1:0] data,
  output logic [AW-1:0] pc_o,
  output logic          carry_o,
  output logic          zero_o,
  output logic [3:0]    state_o
);

  if (DW != AW + 3 || OPW != 3) begin : g_width_check
    $error("accum_cpu_param: DW must equal AW+3 and OPW must be 3");
  end

  state_e         state_q, state_d;
  logic [AW-1:0]  pc_q, pc_d, ar_q, ar_d;
  logic [DW-1:0]  ac_q, ac_d, dr_q, dr_d;
  logic [OPW-1:0] ir_q, ir_d;
  logic           carry_q, carry_d;

  alu_sel_e      alu_sel;
  logic [DW-1:0] alu_res;
  logic          alu_cout;

  // The latched opcode picks the ALU operation for the shared *2 execute step.
  always_comb begin
    case (ir_q)
      OP_SUB:  alu_sel = ALU_SUB;
      OP_AND:  alu_sel = ALU_AND;
      default: alu_sel = ALU_ADD;
    endcase
  end

  accum_cpu_alu #(.DW(DW)) u_alu (
    .ac     (ac_q),
    .dr     (dr_q),
    .sel    (alu_sel),
    .result (alu_res),
    .cout   (alu_cout)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ac_d    = ac_q;
    ar_d    = ar_q;
    dr_d    = dr_q;
    ir_d    = ir_q;
    carry_d = carry_q;
    case (state_q)
      FETCH1: begin
        ar_d    = pc_q;
        state_d = FETCH2;
      end
      FETCH2: if (mem_ready) begin
        dr_d    = d;
        pc_d    = pc_q + AW'(1);
        state_d = FETCH3;
      end
      FETCH3: begin
        ir_d = dr_q[DW-1 -: OPW];
        ar_d = dr_q[AW-1:0];
        case (dr_q[DW-1 -: OPW])
          OP_ADD:  state_d = ADD1;
          OP_SUB:  state_d = SUB1;
          OP_AND:  state_d = AND1;
          OP_INC:  state_d = INC1;
          OP_JMP:  state_d = JMP1;
          OP_JC:   state_d = JC1;
          OP_JZ:   state_d = JZ1;
          OP_MOV:  state_d = MOV1;
          default: state_d = FETCH1;
        endcase
      end
      ADD1: if (mem_ready) begin dr_d = d; state_d = ADD2; end
      SUB1: if (mem_ready) begin dr_d = d; state_d = SUB2; end
      AND1: if (mem_ready) begin dr_d = d; state_d = AND2; end
      ADD2, SUB2, AND2: begin
        ac_d    = alu_res;
        carry_d = alu_cout;
        state_d = FETCH1;
      end
      INC1: begin
        ac_d    = ac_q + DW'(1);
        carry_d = 1'b0;
        state_d = FETCH1;
      end
      JMP1: begin
        pc_d    = dr_q[AW-1:0];
        state_d = FETCH1;
      end
      JC1: begin
        if (carry_q) pc_d = dr_q[AW-1:0];
        state_d = FETCH1;
      end
      JZ1: begin
        if (ac_q == '0) pc_d = dr_q[AW-1:0];
        state_d = FETCH1;
      end
      MOV1: if (mem_ready) state_d = FETCH1;
      default: state_d = FETCH1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= FETCH1;
      pc_q    <= '0;
      ac_q    <= '0;
      ar_q    <= '0;
      dr_q    <= '0;
      ir_q    <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ac_q    <= ac_d;
      ar_q    <= ar_d;
      dr_q    <= dr_d;
      ir_q    <= ir_d;
      carry_q <= carry_d;
    end
  end

  assign read    = (state_q == FETCH2) || (state_q == ADD1) ||
                   (state_q == SUB1)   || (state_q == AND1);
  assign write   = (state_q == MOV1);
  assign a       = ar_q;
  assign data    = ac_q;
  assign pc_o    = pc_q;
  assign carry_o = carry_q;
  assign zero_o  = (ac_q == '0);
  assign state_o = state_q;

endmodule
